// File: rtl/vec_sub_arbiter.sv
// vec_sub_arbiter: round-robin front end for a shared, fully pipelined
// 3-lane fp16 vector-subtract datapath.
//  - One operand pair issued per cycle to the granted requester.
//  - A {valid,id} tag pipe of LATENCY stages follows each op so the result
//    can be steered back to its owner with a one-cycle strobe.
//  - Optional per-requester issue counters: define VSUB_ARB_STATS_EN.
module vec_sub_arbiter #(
    parameter  int NUM_REQ = 4,
    parameter  int LATENCY = 10,
    localparam int IDW     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_REQ-1:0]     i_req_valid,
    input  logic [48*NUM_REQ-1:0]  i_req_a,
    input  logic [48*NUM_REQ-1:0]  i_req_b,
    output logic [NUM_REQ-1:0]     o_req_ready,
    output logic                   o_dp_en,
    output logic [47:0]            o_dp_a,
    output logic [47:0]            o_dp_b,
    input  logic [47:0]            i_dp_q,
    output logic                   o_rsp_valid,
    output logic [IDW-1:0]         o_rsp_id,
    output logic [47:0]            o_rsp_q,
    output logic                   o_busy
`ifdef VSUB_ARB_STATS_EN
    ,
    input  logic                   i_stats_clr,
    output logic [16*NUM_REQ-1:0]  o_issue_cnt
`endif
);

    // Round-robin pointer: the requester searched first this cycle.
    logic [IDW-1:0]               r_rr_ptr;

    // Tag pipe: stage 0 is loaded at the issue edge, stage LATENCY-1 lines
    // up with the cycle in which the datapath presents that op's result.
    logic [LATENCY-1:0]           r_tag_vld;
    logic [LATENCY-1:0][IDW-1:0]  r_tag_id;

    logic                         w_gnt_any;
    logic                         w_gnt_vld;
    logic [IDW-1:0]               w_gnt_id;

    // Priority search starting at r_rr_ptr, wrapping modulo NUM_REQ.
    // Only req_valid and the pointer feed this, never the operands.
    always_comb begin
        int idx;
        idx       = 0;
        w_gnt_any = 1'b0;
        w_gnt_id  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!w_gnt_any && i_req_valid[idx]) begin
                w_gnt_any = 1'b1;
                w_gnt_id  = IDW'(idx);
            end
        end
    end

    // No grant is visible while reset is held, even if requesters are valid.
    assign w_gnt_vld = w_gnt_any & i_rst_n;
    assign o_dp_en   = w_gnt_vld;

    // One-hot ready plus operand mux; operands read zero with no grant.
    always_comb begin
        o_req_ready = '0;
        o_dp_a      = '0;
        o_dp_b      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_gnt_vld && (w_gnt_id == IDW'(i))) begin
                o_req_ready[i] = 1'b1;
                o_dp_a         = i_req_a[48*i +: 48];
                o_dp_b         = i_req_b[48*i +: 48];
            end
        end
    end

    // Advance the pointer past the winner; explicit wrap keeps it legal
    // when NUM_REQ is not a power of two.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rr_ptr <= '0;
        end else if (w_gnt_vld) begin
            if (w_gnt_id == IDW'(NUM_REQ - 1))
                r_rr_ptr <= '0;
            else
                r_rr_ptr <= w_gnt_id + 1'b1;
        end
    end

    // Shift {valid,id} down the tag pipe every cycle; reset drops all
    // in-flight tags so their results are never reported.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            r_tag_vld[0] <= w_gnt_vld;
            r_tag_id[0]  <= w_gnt_id;
            for (int s = 1; s < LATENCY; s++) begin
                r_tag_vld[s] <= r_tag_vld[s-1];
                r_tag_id[s]  <= r_tag_id[s-1];
            end
        end
    end

    assign o_rsp_valid = r_tag_vld[LATENCY-1];
    assign o_rsp_id    = r_tag_id[LATENCY-1];
    assign o_rsp_q     = i_dp_q;
    assign o_busy      = |r_tag_vld;

`ifdef VSUB_ARB_STATS_EN
    // Saturating per-requester transfer counters; clear wins over count.
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_cnt
        logic [15:0] r_cnt;

        // Count accepted transfers for requester g.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n)
                r_cnt <= '0;
            else if (i_stats_clr)
                r_cnt <= '0;
            else if (i_req_valid[g] && o_req_ready[g] && (r_cnt != 16'hFFFF))
                r_cnt <= r_cnt + 16'd1;
        end

        assign o_issue_cnt[16*g +: 16] = r_cnt;
    end
`endif

endmodule

// File: tb/tb_vec_sub_arbiter.sv
// Directed bench for vec_sub_arbiter with a behavioural LATENCY-deep
// fp16 subtract pipe standing in for the datapath.
module tb_vec_sub_arbiter;
    localparam int NR  = 4;
    localparam int LAT = 10;
    localparam int IDW = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NR-1:0]     req_valid = '0;
    logic [48*NR-1:0]  req_a = '0;
    logic [48*NR-1:0]  req_b = '0;
    logic [NR-1:0]     req_ready;
    logic              dp_en;
    logic [47:0]       dp_a, dp_b, dp_q;
    logic              rsp_valid;
    logic [IDW-1:0]    rsp_id;
    logic [47:0]       rsp_q;
    logic              busy;
`ifdef VSUB_ARB_STATS_EN
    logic              stats_clr = 1'b0;
    logic [16*NR-1:0]  issue_cnt;
`endif

    int n_run  = 0;
    int n_fail = 0;

    vec_sub_arbiter #(.NUM_REQ(NR), .LATENCY(LAT)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_req_valid (req_valid),
        .i_req_a     (req_a),
        .i_req_b     (req_b),
        .o_req_ready (req_ready),
        .o_dp_en     (dp_en),
        .o_dp_a      (dp_a),
        .o_dp_b      (dp_b),
        .i_dp_q      (dp_q),
        .o_rsp_valid (rsp_valid),
        .o_rsp_id    (rsp_id),
        .o_rsp_q     (rsp_q),
        .o_busy      (busy)
`ifdef VSUB_ARB_STATS_EN
        ,
        .i_stats_clr (stats_clr),
        .o_issue_cnt (issue_cnt)
`endif
    );

    always #5 clk = ~clk;

    // fp16 subtract for positive normal operands with a >= b (truncating).
    function automatic logic [15:0] fsub16(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, ma, mb, d;
        ea = int'(a[14:10]);
        eb = int'(b[14:10]);
        ma = int'({1'b1, a[9:0]});
        mb = int'({1'b1, b[9:0]});
        if (ea - eb > 11) mb = 0;
        else mb = mb >> (ea - eb);
        d = ma - mb;
        if (d <= 0) return 16'h0000;
        while (d < 'h400) begin
            d  = d << 1;
            ea = ea - 1;
        end
        return {1'b0, ea[4:0], d[9:0]};
    endfunction

    function automatic logic [47:0] vsub(input logic [47:0] a, input logic [47:0] b);
        return {fsub16(a[47:32], b[47:32]), fsub16(a[31:16], b[31:16]), fsub16(a[15:0], b[15:0])};
    endfunction

    // Datapath stand-in: result visible LAT cycles after the issue cycle.
    logic [LAT-1:0][47:0] dq;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq <= '0;
        end else begin
            dq[0] <= dp_en ? vsub(dp_a, dp_b) : 48'h0;
            for (int s = 1; s < LAT; s++) dq[s] <= dq[s-1];
        end
    end
    assign dp_q = dq[LAT-1];

    // Hand-computed lane pairs: a - b = r.
    logic [15:0] PA [8] = '{16'h3C00, 16'h4000, 16'h4400, 16'h4400, 16'h3800, 16'h4200, 16'h4000, 16'h3C00};
    logic [15:0] PB [8] = '{16'h3800, 16'h3C00, 16'h3C00, 16'h4000, 16'h3800, 16'h3C00, 16'h3800, 16'h3400};
    logic [15:0] PR [8] = '{16'h3800, 16'h3C00, 16'h4200, 16'h4000, 16'h0000, 16'h4000, 16'h3E00, 16'h3A00};

    function automatic logic [47:0] va(input int s);
        return {PA[s%8], PA[(s+1)%8], PA[(s+2)%8]};
    endfunction
    function automatic logic [47:0] vb(input int s);
        return {PB[s%8], PB[(s+1)%8], PB[(s+2)%8]};
    endfunction
    function automatic logic [47:0] vr(input int s);
        return {PR[s%8], PR[(s+1)%8], PR[(s+2)%8]};
    endfunction

    task automatic set_op(input int i, input int s);
        req_a[48*i +: 48] = va(s);
        req_b[48*i +: 48] = vb(s);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        req_valid = '0;
        rst_n     = 1'b0;
        tick();
        rst_n     = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        for (int i = 0; i < NR; i++) set_op(i, i);

        // Reset state, with all requesters valid during reset.
        req_valid = 4'hF;
        #12;
        chk("rst_ready", req_ready, 4'b0000);
        chk("rst_dp_en", dp_en, 1'b0);
        chk("rst_dp_a", dp_a, 48'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_id", rsp_id, 2'd0);
        chk("rst_busy", busy, 1'b0);
        tick();
        req_valid = '0;
        rst_n     = 1'b1;

        // Single op from requester 1.
        tick();
        req_valid = 4'b0010;
        req_a[48*1 +: 48] = 48'h3C00_4000_3800;
        req_b[48*1 +: 48] = 48'h3800_3C00_3800;
        #1;
        chk("single_ready", req_ready, 4'b0010);
        chk("single_dp_en", dp_en, 1'b1);
        chk("single_dp_a", dp_a, 48'h3C00_4000_3800);
        chk("single_dp_b", dp_b, 48'h3800_3C00_3800);
        for (int k = 1; k <= 10; k++) begin
            tick();
            req_valid = '0;
            #1;
            chk("single_busy", busy, 1'b1);
            if (k < 10) chk("single_early", rsp_valid, 1'b0);
        end
        chk("single_rsp_valid", rsp_valid, 1'b1);
        chk("single_rsp_id", rsp_id, 2'd1);
        chk("single_rsp_q", rsp_q, 48'h3800_3C00_0000);
        tick();
        #1;
        chk("single_tail", rsp_valid, 1'b0);
        chk("single_idle", busy, 1'b0);

        // Fairness from reset: all valid for 8 cycles.
        do_reset();
        for (int i = 0; i < NR; i++) set_op(i, i);
        tick();
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("fair_gnt", req_ready, 64'(1) << (k % 4));
            chk("fair_dp_a", dp_a, va(k % 4));
            tick();
        end
        req_valid = '0;
        tick();
        tick();
        for (int k = 0; k < 8; k++) begin
            #1;
            chk("fair_rsp_valid", rsp_valid, 1'b1);
            chk("fair_rsp_id", rsp_id, 64'(k % 4));
            chk("fair_rsp_q", rsp_q, vr(k % 4));
            tick();
        end
        #1;
        chk("fair_tail", rsp_valid, 1'b0);

        // Pointer skip: move pointer to 2 via a grant to 1, then 0 and 3 valid.
        tick();
        req_valid = 4'b0010;
        #1;
        chk("skip_pre", req_ready, 4'b0010);
        tick();
        req_valid = 4'b1001;
        #1;
        chk("skip_g3a", req_ready, 4'b1000);
        tick();
        #1;
        chk("skip_g0", req_ready, 4'b0001);
        tick();
        #1;
        chk("skip_g3b", req_ready, 4'b1000);
        tick();
        req_valid = '0;
        #1;
        chk("idle_ready", req_ready, 4'b0000);
        tick();
        tick();
        req_valid = 4'hF;
        #1;
        chk("idle_ptr_held", req_ready, 4'b0001);
        req_valid = '0;
        for (int k = 0; k < 12; k++) tick();
        chk("skip_drained", busy, 1'b0);

        // Back-to-back single requester 2 with changing operands.
        tick();
        req_valid = 4'b0100;
        for (int k = 0; k < 5; k++) begin
            set_op(2, 3 + k);
            #1;
            chk("b2b_ready", req_ready, 4'b0100);
            tick();
        end
        req_valid = '0;
        for (int k = 0; k < 5; k++) tick();
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("b2b_rsp_valid", rsp_valid, 1'b1);
            chk("b2b_rsp_id", rsp_id, 2'd2);
            chk("b2b_rsp_q", rsp_q, vr(3 + k));
            tick();
        end
        #1;
        chk("b2b_tail", rsp_valid, 1'b0);

        // Reset mid-flight: three ops issued (grants 3,0,1), then reset.
        for (int i = 0; i < NR; i++) set_op(i, i);
        tick();
        req_valid = 4'hF;
        #1;
        chk("mid_first_gnt", req_ready, 4'b1000);
        tick();
        tick();
        tick();
        chk("mid_busy_pre", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", req_ready, 4'b0000);
        chk("mid_rst_dp_en", dp_en, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        tick();
        req_valid = '0;
        rst_n     = 1'b1;
        seen = 0;
        for (int k = 0; k < 14; k++) begin
            tick();
            if (rsp_valid) seen++;
        end
        chk("mid_no_rsp", 64'(seen), 64'd0);
        chk("mid_busy_post", busy, 1'b0);
        req_valid = 4'hF;
        #1;
        chk("mid_ptr_zero", req_ready, 4'b0001);
        req_valid = '0;

`ifdef VSUB_ARB_STATS_EN
        // Stats: three transfers from requester 0, then clear with a transfer.
        do_reset();
        tick();
        req_valid = 4'b0001;
        tick();
        tick();
        tick();
        req_valid = '0;
        #1;
        chk("cnt0_three", issue_cnt[15:0], 16'd3);
        chk("cnt1_zero", issue_cnt[31:16], 16'd0);
        stats_clr = 1'b1;
        req_valid = 4'b0001;
        tick();
        stats_clr = 1'b0;
        req_valid = '0;
        #1;
        chk("cnt0_clr", issue_cnt[15:0], 16'd0);
        req_valid = 4'b0010;
        tick();
        req_valid = '0;
        #1;
        chk("cnt1_one", issue_cnt[31:16], 16'd1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule

// File: doc/vec_sub_arbiter.md
Name: vec_sub_arbiter

Overview:
- Round-robin arbiter that shares one pipelined 3-lane fp16 vector-subtract datapath among NUM_REQ requesters.
- Accepts at most one 48-bit operand pair per cycle and drives it into the datapath.
- Carries a requester ID and valid bit down a tag pipeline matched to the datapath latency.
- Returns each result to its originating requester with a one-cycle response strobe.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- LATENCY, 10, datapath latency in cycles from dp_en/operands to dp_q valid (>=1).
- IDW, $clog2(NUM_REQ), requester ID width (derived, not overridden).

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester operation request.
- req_a  in  48*NUM_REQ  operand A for each requester; requester i occupies [48*i+47:48*i]; lanes {x,y,z} = {[47:32],[31:16],[15:0]}.
- req_b  in  48*NUM_REQ  operand B, same packing.
- req_ready  out  NUM_REQ  one-hot grant; transfer for requester i occurs when req_valid[i] & req_ready[i].
- dp_en  out  1  issue strobe to the datapath.
- dp_a  out  48  operand A to the datapath.
- dp_b  out  48  operand B to the datapath.
- dp_q  in  48  datapath result (a-b per lane), valid LATENCY cycles after issue.
- rsp_valid  out  1  result strobe.
- rsp_id  out  IDW  requester owning the current result.
- rsp_q  out  48  result; equals dp_q when rsp_valid is high.
- busy  out  1  high while any op is in flight.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rr_ptr=0, all tag-pipe stages invalid.
  - rsp_valid=0, rsp_id=0, busy=0, dp_en=0.
  - req_ready=0 while in reset.
- Arbitration (combinational from req_valid and rr_ptr):
  - Grant the first requester with req_valid high, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - req_ready is one-hot for the granted requester, or all zero if nothing is requesting.
  - req_ready must not depend on req_a/req_b.
- Issue:
  - When a grant exists, dp_en=1 and dp_a/dp_b are driven from the granted requester's operands in the same cycle.
  - dp_a/dp_b are combinational muxes; they read 0 when dp_en=0.
  - The datapath is fully pipelined, so one issue per cycle is allowed with no issue-side backpressure.
- Pointer update:
  - On the posedge after a grant to requester g, rr_ptr <= (g+1) mod NUM_REQ.
  - With no grant, rr_ptr holds.
  - With all requesters continuously valid, service order is 0,1,2,...,NUM_REQ-1,0,...
- Tag pipeline:
  - LATENCY-stage shift register of {valid, id}.
  - Stage 0 is loaded with {dp_en, granted id} each posedge.
  - Registered outputs at the final stage:
    - rsp_valid = final-stage valid.
    - rsp_id = final-stage id.
  - For an op issued at edge t, rsp_valid is high in the cycle after edge t+LATENCY-1. That is the cycle in which dp_q for that op is valid; total latency LATENCY cycles.
  - rsp_q passes dp_q through combinationally.
  - No response backpressure: a requester must take the result on the strobe.
  - Responses return in issue order.
- busy = OR of all tag-stage valid bits.
- Boundary conditions:
  - A single requester asserting valid every cycle is granted every cycle, giving back-to-back rsp_valid pulses.
  - req_valid deasserted without a grant: no transfer, no state change.
  - Reset mid-operation: all in-flight tags are cleared and their results dropped. The datapath is reset by the same rst_n.
  - NUM_REQ not a power of two: rr_ptr wraps from NUM_REQ-1 to 0 and never holds an illegal value.

Optional Feature:
- Macro VSUB_ARB_STATS_EN.
- When defined:
  - Adds output issue_cnt, NUM_REQ*16 bits: one saturating 16-bit counter per requester, incremented on each transfer.
  - Counters reset to 0 and saturate at 0xFFFF.
  - Adds input stats_clr (1 bit); when high, all counters go to 0 next edge, taking priority over increment.
- When undefined: neither port nor the counters exist; behaviour is otherwise identical.

Test Plan:
- Single op: requester 1, a={0x3C00,0x4000,0x3800}, b={0x3800,0x3C00,0x3800} -> req_ready=4'b0010 same cycle; rsp_valid exactly 10 cycles later with rsp_id=1 and rsp_q={0x3800,0x3C00,0x0000}; busy high over the interval.
- Fairness: all 4 requesters valid continuously for 8 cycles from reset -> grants in order 0,1,2,3,0,1,2,3; rsp_id sequence matches 10 cycles later; no bubbles.
- Pointer skip: rr_ptr=2, only requesters 0 and 3 valid -> grant 3, then 0, then 3.
- Back-to-back single requester: requester 2 valid for 5 cycles -> 5 consecutive rsp_valid pulses with rsp_id=2 and results in issue order.
- Reset mid-flight: issue 3 ops, then assert rst_n low at cycle 4 -> rsp_valid never asserts for them; busy=0 and rr_ptr=0 after release.
- Stats (VSUB_ARB_STATS_EN): 3 transfers from requester 0 -> issue_cnt[15:0]=3; stats_clr together with a transfer -> counter reads 0.
